// File: rtl/seg_display_pkg.sv
// rtl/seg_display_pkg.sv - segment patterns and hex decode function for the display scanner
package seg_display_pkg;

    localparam logic [6:0] SEG_0 = 7'b0111111;
    localparam logic [6:0] SEG_1 = 7'b0000110;
    localparam logic [6:0] SEG_2 = 7'b1011011;
    localparam logic [6:0] SEG_3 = 7'b1001111;
    localparam logic [6:0] SEG_4 = 7'b1100110;
    localparam logic [6:0] SEG_5 = 7'b1101101;
    localparam logic [6:0] SEG_6 = 7'b1111101;
    localparam logic [6:0] SEG_7 = 7'b0000111;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1101111;
    localparam logic [6:0] SEG_A = 7'b1110111;
    localparam logic [6:0] SEG_B = 7'b1111100;
    localparam logic [6:0] SEG_C = 7'b0111001;
    localparam logic [6:0] SEG_D = 7'b1011110;
    localparam logic [6:0] SEG_E = 7'b1111001;
    localparam logic [6:0] SEG_F = 7'b1110001;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Position of the decimal point in the {dp,g,f,e,d,c,b,a} cathode byte.
    localparam int DP_BIT = 7;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        case (nibble)
            4'h0:    return SEG_0;
            4'h1:    return SEG_1;
            4'h2:    return SEG_2;
            4'h3:    return SEG_3;
            4'h4:    return SEG_4;
            4'h5:    return SEG_5;
            4'h6:    return SEG_6;
            4'h7:    return SEG_7;
            4'h8:    return SEG_8;
            4'h9:    return SEG_9;
            4'hA:    return SEG_A;
            4'hB:    return SEG_B;
            4'hC:    return SEG_C;
            4'hD:    return SEG_D;
            4'hE:    return SEG_E;
            default: return SEG_F;
        endcase
    endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// rtl/seg_hex_decoder.sv - combinational nibble to active-high gfedcba pattern
module seg_hex_decoder
    import seg_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seg_display_scanner.sv
// rtl/seg_display_scanner.sv - multiplexed N-digit seven-segment scanner with double buffer, LZ blanking and PWM
module seg_display_scanner
    import seg_display_pkg::*;
#(
    parameter int NUM_DIGITS       = 4,
    parameter int CLK_DIV          = 100000,
    parameter int BRIGHT_W         = 4,
    parameter int ANODE_ACTIVE_LOW = 1,
    parameter int SEG_ACTIVE_LOW   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    load,
    input  logic                    lz_en,
    input  logic [BRIGHT_W-1:0]     bright,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [7:0]              catode,
    output logic                    frame_done
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [NUM_DIGITS-1:0] AN_OFF =
        (ANODE_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
    localparam logic [7:0] CAT_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

    logic [PW-1:0]           pcnt;
    logic [SW-1:0]           slot;
    logic [BRIGHT_W-1:0]     pwm_cnt;
    logic [4*NUM_DIGITS-1:0] pend_data;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic [4*NUM_DIGITS-1:0] disp_data;
    logic [NUM_DIGITS-1:0]   disp_dp;
    logic [NUM_DIGITS-1:0]   blank;

    logic                    tick;
    logic                    wrap;
    logic [4*NUM_DIGITS-1:0] commit_data;
    logic [NUM_DIGITS-1:0]   commit_dp;
    logic [NUM_DIGITS-1:0]   next_blank;
    logic                    lz_run;
    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    cur_blank;
    logic [6:0]              cur_seg;
    logic                    digit_on;
    logic [NUM_DIGITS-1:0]   an_act;
    logic [7:0]              cat_act;

    assign tick = (pcnt == PW'(CLK_DIV - 1));
    assign wrap = tick && (slot == SW'(NUM_DIGITS - 1));

    // A load landing on the commit cycle bypasses the pending buffer.
    always_comb begin
        commit_data = load ? data : pend_data;
        commit_dp   = load ? dp : pend_dp;
    end

    always_comb begin
        next_blank = '0;
        lz_run     = lz_en;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (lz_run && commit_data[4*i +: 4] == 4'h0 && !commit_dp[i]) begin
                next_blank[i] = 1'b1;
            end else begin
                lz_run = 1'b0;
            end
        end
    end

    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (slot == SW'(i)) begin
                cur_nib   = disp_data[4*i +: 4];
                cur_dp    = disp_dp[i];
                cur_blank = blank[i];
            end
        end
    end

    seg_hex_decoder u_dec (
        .nibble (cur_nib),
        .seg    (cur_seg)
    );

    assign digit_on = (pwm_cnt <= bright) && !cur_blank;

    always_comb begin
        an_act = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            an_act[i] = digit_on && (slot == SW'(i));
        end
        cat_act = {1'b0, SEG_BLANK};
        if (digit_on) begin
            cat_act[6:0]    = cur_seg;
            cat_act[DP_BIT] = cur_dp;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcnt       <= '0;
            slot       <= '0;
            pwm_cnt    <= '0;
            pend_data  <= '0;
            pend_dp    <= '0;
            disp_data  <= '0;
            disp_dp    <= '0;
            blank      <= '0;
            frame_done <= 1'b0;
            anode      <= AN_OFF;
            catode     <= CAT_OFF;
        end else begin
            pcnt    <= tick ? '0 : pcnt + PW'(1);
            pwm_cnt <= pwm_cnt + BRIGHT_W'(1);
            if (tick) begin
                slot <= wrap ? '0 : slot + SW'(1);
            end
            if (load) begin
                pend_data <= data;
                pend_dp   <= dp;
            end
            if (wrap) begin
                disp_data <= commit_data;
                disp_dp   <= commit_dp;
                blank     <= next_blank;
            end
            frame_done <= wrap;
            anode      <= an_act ^ AN_OFF;
            catode     <= cat_act ^ CAT_OFF;
        end
    end

endmodule

// File: tb/tb_seg_display_scanner.sv
// tb/tb_seg_display_scanner.sv - scoreboard bench for seg_display_scanner
module tb_seg_display_scanner;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] data = 16'h0;
    logic [3:0]  dp = 4'h0;
    logic        load = 1'b0;
    logic        lz_en = 1'b0;
    logic [3:0]  bright = 4'hF;
    logic [3:0]  anode, anode_b;
    logic [7:0]  catode, catode_b;
    logic        frame_done, frame_done_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] an;
        logic [7:0] ca;
    } exp_t;
    exp_t sb[$];
    int   exp_cnt[$];

    logic [6:0] seg_tbl [0:15] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    seg_display_scanner #(
        .NUM_DIGITS(4), .CLK_DIV(4), .BRIGHT_W(4),
        .ANODE_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)
    ) u_dut (
        .clk(clk), .reset(reset), .data(data), .dp(dp), .load(load),
        .lz_en(lz_en), .bright(bright), .anode(anode), .catode(catode),
        .frame_done(frame_done)
    );

    seg_display_scanner #(
        .NUM_DIGITS(4), .CLK_DIV(32), .BRIGHT_W(4),
        .ANODE_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)
    ) u_dut_b (
        .clk(clk), .reset(reset), .data(data), .dp(dp), .load(load),
        .lz_en(lz_en), .bright(bright), .anode(anode_b), .catode(catode_b),
        .frame_done(frame_done_b)
    );

    always #5 clk = ~clk;

    // Queue one frame of expectations: 4 cycles per slot, slot 0 first.
    task automatic push_frame(input logic [15:0] d, input logic [3:0] p, input logic [3:0] bl);
        exp_t e;
        for (int s = 0; s < 4; s++) begin
            if (bl[s]) begin
                e.an = 4'hF;
                e.ca = 8'hFF;
            end else begin
                e.an = ~(4'b0001 << s);
                e.ca = ~{p[s], seg_tbl[d[s*4 +: 4]]};
            end
            repeat (4) sb.push_back(e);
        end
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p);
        data = d;
        dp   = p;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_frame(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (frame_done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        #1 reset = 1'b0;
        #1;
        checks++;
        if (anode !== 4'b1111 || catode !== 8'hFF || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_async anode=%b catode=%h frame_done=%b expected 1111 ff 0",
                     anode, catode, frame_done);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (anode !== 4'b1111 || catode !== 8'hFF || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold anode=%b catode=%h frame_done=%b expected 1111 ff 0",
                     anode, catode, frame_done);
        end
        reset = 1'b1;
    endtask

    task automatic test_basic_scan;
        bit ok;
        exp_t e;
        lz_en = 1'b0;
        bright = 4'hF;
        do_load(16'h12AF, 4'h0);
        wait_frame(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL basic_scan_wait frame_done not seen within bound");
        end
        push_frame(16'h12AF, 4'h0, 4'h0);
        for (int j = 1; j <= 16; j++) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (anode !== e.an || catode !== e.ca) begin
                errors++;
                $display("FAIL basic_scan j=%0d anode=%b catode=%h expected %b %h",
                         j, anode, catode, e.an, e.ca);
            end
            checks++;
            if (frame_done !== (j == 16)) begin
                errors++;
                $display("FAIL basic_scan_frame_done j=%0d got=%b expected=%b",
                         j, frame_done, (j == 16));
            end
            if (j == 1) begin
                checks++;
                if (anode !== 4'b1110 || catode !== 8'h8E) begin
                    errors++;
                    $display("FAIL basic_scan_slot0 anode=%b catode=%h expected 1110 8e", anode, catode);
                end
            end
            if (j == 16) begin
                checks++;
                if (anode !== 4'b0111 || catode !== 8'hF9) begin
                    errors++;
                    $display("FAIL basic_scan_slot3 anode=%b catode=%h expected 0111 f9", anode, catode);
                end
            end
        end
    endtask

    task automatic test_no_tearing;
        bit ok;
        exp_t e;
        do_load(16'h1111, 4'h0);
        wait_frame(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL no_tearing_wait frame_done not seen within bound");
        end
        push_frame(16'h1111, 4'h0, 4'h0);
        push_frame(16'h2222, 4'h0, 4'h0);
        for (int j = 1; j <= 32; j++) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (anode !== e.an || catode !== e.ca) begin
                errors++;
                $display("FAIL no_tearing j=%0d anode=%b catode=%h expected %b %h",
                         j, anode, catode, e.an, e.ca);
            end
            if (j == 9) begin
                data = 16'h2222;
                load = 1'b1;
            end
            if (j == 10) load = 1'b0;
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        exp_t e;
        do_load(16'h4444, 4'h0);
        wait_frame(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL back_to_back_wait frame_done not seen within bound");
        end
        push_frame(16'h4444, 4'h0, 4'h0);
        push_frame(16'h5555, 4'h2, 4'h0);
        for (int j = 1; j <= 32; j++) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (anode !== e.an || catode !== e.ca) begin
                errors++;
                $display("FAIL back_to_back j=%0d anode=%b catode=%h expected %b %h",
                         j, anode, catode, e.an, e.ca);
            end
            load = 1'b0;
            if (j == 5) begin
                data = 16'h6666;
                dp   = 4'h0;
                load = 1'b1;
            end
            if (j == 15) begin
                data = 16'h5555;
                dp   = 4'h2;
                load = 1'b1;
            end
        end
        dp = 4'h0;
    endtask

    task automatic test_lz;
        bit ok;
        exp_t e;
        logic [15:0] d_tab [3] = '{16'h0050, 16'h0000, 16'h0050};
        logic [3:0]  p_tab [3] = '{4'b0000, 4'b0000, 4'b1000};
        logic [3:0]  b_tab [3] = '{4'b1100, 4'b1110, 4'b0000};
        lz_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            do_load(d_tab[k], p_tab[k]);
            wait_frame(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL lz_wait case=%0d frame_done not seen within bound", k);
            end
            push_frame(d_tab[k], p_tab[k], b_tab[k]);
            for (int j = 1; j <= 16; j++) begin
                @(negedge clk);
                e = sb.pop_front();
                checks++;
                if (anode !== e.an || catode !== e.ca) begin
                    errors++;
                    $display("FAIL lz case=%0d j=%0d anode=%b catode=%h expected %b %h",
                             k, j, anode, catode, e.an, e.ca);
                end
            end
        end
        dp = 4'h0;
        lz_en = 1'b0;
    endtask

    task automatic test_brightness;
        bit ok;
        int cnt_a, cnt_b, multi, expv;
        logic [3:0] br_tab [3] = '{4'd3, 4'd15, 4'd0};
        lz_en = 1'b0;
        do_load(16'h8888, 4'h0);
        ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (frame_done_b) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL brightness_wait frame_done_b not seen within bound");
        end
        for (int k = 0; k < 3; k++) begin
            bright = br_tab[k];
            exp_cnt.push_back((int'(br_tab[k]) + 1) * 2);
            repeat (2) @(negedge clk);
            cnt_a = 0;
            cnt_b = 0;
            multi = 0;
            for (int j = 0; j < 32; j++) begin
                @(negedge clk);
                if (anode != 4'hF) cnt_a++;
                if (anode_b != 4'hF) cnt_b++;
                if ($countones(~anode) > 1 || $countones(~anode_b) > 1) multi++;
            end
            expv = exp_cnt.pop_front();
            checks++;
            if (cnt_a != expv) begin
                errors++;
                $display("FAIL brightness_div4 bright=%0d active=%0d expected=%0d", br_tab[k], cnt_a, expv);
            end
            checks++;
            if (cnt_b != expv) begin
                errors++;
                $display("FAIL brightness_div32 bright=%0d active=%0d expected=%0d", br_tab[k], cnt_b, expv);
            end
            checks++;
            if (multi != 0) begin
                errors++;
                $display("FAIL onehot_anode bright=%0d cycles_with_multiple=%0d expected=0", br_tab[k], multi);
            end
        end
        bright = 4'hF;
    endtask

    task automatic test_reset_mid_frame;
        bit ok;
        exp_t e;
        do_load(16'h1234, 4'h0);
        wait_frame(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL reset_mid_wait frame_done not seen within bound");
        end
        repeat (9) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (anode !== 4'b1111 || catode !== 8'hFF || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_async anode=%b catode=%h frame_done=%b expected 1111 ff 0",
                     anode, catode, frame_done);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        push_frame(16'h0000, 4'h0, 4'h0);
        for (int j = 1; j <= 16; j++) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (anode !== e.an || catode !== e.ca) begin
                errors++;
                $display("FAIL reset_mid_resume j=%0d anode=%b catode=%h expected %b %h",
                         j, anode, catode, e.an, e.ca);
            end
            checks++;
            if (frame_done !== (j == 16)) begin
                errors++;
                $display("FAIL reset_mid_frame_done j=%0d got=%b expected=%b", j, frame_done, (j == 16));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_no_tearing();
        test_back_to_back();
        test_lz();
        test_brightness();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_display_scanner.md
Name: seg_display_scanner

Overview:
Parametrised successor to the team's fixed 4-digit hex display path: a multiplexed N-digit seven-segment driver with the prescaler, scan state machine and hex decoder in one block. Adds per-digit decimal points, a double-buffered data load, leading-zero suppression, PWM brightness, configurable output polarity and a frame-boundary pulse. It sits between register or datapath debug values and the board's anode/cathode pins.

Parameters:
- NUM_DIGITS, 4: digits scanned, legal range 1..16.
- CLK_DIV, 100000: clk cycles per digit slot, must be >=1.
- BRIGHT_W, 4: width of the brightness control and of the PWM counter.
- ANODE_ACTIVE_LOW, 1: 1 = anode outputs are active-low.
- SEG_ACTIVE_LOW, 1: 1 = segment and decimal-point outputs are active-low.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- data  in  4*NUM_DIGITS  hex nibbles; nibble i drives digit i, and digit 0 is the rightmost digit.
- dp  in  NUM_DIGITS  decimal-point enables, one per digit.
- load  in  1  strobe; captures data and dp into the pending buffer.
- lz_en  in  1  leading-zero suppression enable, sampled at commit.
- bright  in  BRIGHT_W  brightness level.
- anode  out  NUM_DIGITS  digit enables, registered.
- catode  out  8  segments {dp,g,f,e,d,c,b,a}, registered.
- frame_done  out  1  one-cycle pulse at each frame wrap.

Behaviour:
- Reset (reset=0, asynchronous):
  - All counters, the pending buffer, the display buffer and the blank mask clear to 0.
  - anode goes to all-inactive and catode to all-off, with polarity applied.
  - frame_done goes to 0.
  - Takes effect mid-frame without waiting for a clock edge; scanning restarts at slot 0.
- Prescaler: pcnt counts 0..CLK_DIV-1. tick=1 when pcnt==CLK_DIV-1. With CLK_DIV=1, tick is high every cycle.
- Slot state machine:
  - slot counts 0..NUM_DIGITS-1 and advances on tick.
  - On tick with slot==NUM_DIGITS-1, it wraps to 0, frame_done pulses for that cycle, and the commit happens.
- Double buffer:
  - load=1 captures data and dp into the pending buffer. The last load before a commit wins.
  - Commit copies pending to display and recomputes the blank mask from the committed value and lz_en.
  - If load and commit fall in the same cycle, the newly loaded value is the one committed.
  - The display never changes mid-frame, so there is no tearing.
- Leading-zero suppression (lz_en=1): scanning from digit NUM_DIGITS-1 downward, a digit is blanked while its nibble==0 and its dp==0. Suppression stops at the first digit that fails this test. Digit 0 is never blanked. With lz_en=0 the blank mask is all 0.
- PWM:
  - pwm_cnt is a BRIGHT_W-bit free-running counter that increments every clk and wraps.
  - on = (pwm_cnt <= bright). bright=0 gives a 1/2^BRIGHT_W duty; bright=all-ones gives a continuous digit.
- Output stage (registered, 1-cycle latency from slot, pwm_cnt and mask):
  - If on and digit[slot] is not blanked: the anode bit for slot is active, all other anode bits are inactive, and catode = {dp[slot], seg(nibble[slot])}.
  - Otherwise all anodes are inactive and catode is all-off.
  - Polarity is applied after the decode.
- Segment map (gfedcba): 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111, A=1110111, B=1111100, C=0111001, D=1011110, E=1111001, F=1110001.
- At most one anode bit is ever active.

Decomposition:
- Package seg_display_pkg holds:
  - the 16 segment-pattern constants,
  - the SEG_BLANK constant,
  - a hex_to_seg function,
  - the dp bit-index constant.
- One sub-module, seg_hex_decoder: combinational nibble to 7-bit pattern, built on the package function. Polarity is handled in the parent.
- Prescaler, slot FSM, buffers and PWM stay in the parent.

Test Plan:
All cases use NUM_DIGITS=4, CLK_DIV=4 and BRIGHT_W=4 unless stated.
1. Reset: hold reset=0 for 10 cycles -> anode=4'b1111, catode=8'hFF, frame_done=0, with no clock edge needed after assertion.
2. Basic scan: load data=16'h12AF, dp=0, bright=15, lz_en=0. After the first frame_done:
   - slot 0 -> anode=4'b1110, catode=8'h8E.
   - slot 3 -> anode=4'b0111, catode=8'hF9.
   - Each slot lasts 4 cycles, and frame_done recurs every 16 cycles.
3. No tearing: load 16'h1111 at frame start, then load 16'h2222 during slot 2 -> digits 2 and 3 still show '1' for the rest of that frame; all digits show '2' from the next slot 0.
4. Leading-zero suppression, lz_en=1:
   - data=16'h0050 -> digits 3 and 2 blanked (anode never active in their slots); digits 1 and 0 show '5' and '0'.
   - data=0 -> only digit 0 is lit.
   - data=16'h0050 with dp=4'b1000 -> digit 3 shows '0.' and digit 2 shows '0'.
5. Brightness: CLK_DIV=32, bright=3 -> within each slot the anode is active on exactly 8 of 32 cycles (pwm_cnt 0..3, twice per slot). bright=15 -> anode continuously active.
6. Reset mid-frame: assert reset=0 during slot 2 -> outputs go inactive immediately. After release, scanning resumes at slot 0, and since the display buffer holds 0 the display shows '0000'.
